// File: rtl/grid_draw_pkg.sv
// Shared widths, FSM encodings and helpers for the grid draw scheduler.
package grid_draw_pkg;

  localparam int unsigned TILE_ID_W       = 4;
  localparam int unsigned X_W             = 8;
  localparam int unsigned Y_W             = 7;
  localparam int unsigned CELL_W          = 4;
  localparam int unsigned SNAP_MAX_W      = 64;
  localparam int unsigned DEF_CELL_CYCLES = 321;
  localparam int unsigned SCREEN_W        = 160;
  localparam int unsigned SCREEN_H        = 120;

  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StClear = 3'd1;
  localparam state_t StDraw  = 3'd2;
  localparam state_t StNext  = 3'd3;
  localparam state_t StDone  = 3'd4;

  function automatic logic [TILE_ID_W-1:0] tile_at(input logic [SNAP_MAX_W-1:0] snap,
                                                   input logic [CELL_W-1:0]     idx);
    return snap[{idx, 2'b00} +: TILE_ID_W];
  endfunction

endpackage

// File: rtl/cell_cursor.sv
// Row-major cell walker; tracks row/col and the cell's pixel origin incrementally.
module cell_cursor
  import grid_draw_pkg::*;
#(
  parameter int unsigned GRID_N   = 3,
  parameter int unsigned TILE_PX  = 32,
  parameter int unsigned ORIGIN_X = 32,
  parameter int unsigned ORIGIN_Y = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_clear,
  input  logic           i_advance,
  output logic [1:0]     o_row,
  output logic [1:0]     o_col,
  output logic [X_W-1:0] o_x_base,
  output logic [Y_W-1:0] o_y_base,
  output logic           o_last
);

  localparam logic [1:0]     LastIdx = 2'(GRID_N - 1);
  localparam logic [X_W-1:0] OrgX    = X_W'(ORIGIN_X);
  localparam logic [Y_W-1:0] OrgY    = Y_W'(ORIGIN_Y);
  localparam logic [X_W-1:0] StepX   = X_W'(TILE_PX);
  localparam logic [Y_W-1:0] StepY   = Y_W'(TILE_PX);

  logic [1:0]     r_row;
  logic [1:0]     r_col;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_row_end;

  assign w_row_end = (r_col == LastIdx);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row <= '0;
      r_col <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
      r_x   <= OrgX;
      r_y   <= OrgY;
    end else if (i_advance) begin
      if (w_row_end) begin
        r_col <= '0;
        r_row <= r_row + 2'd1;
        r_x   <= OrgX;
        r_y   <= r_y + StepY;
      end else begin
        r_col <= r_col + 2'd1;
        r_x   <= r_x + StepX;
      end
    end
  end

  assign o_row    = r_row;
  assign o_col    = r_col;
  assign o_x_base = r_x;
  assign o_y_base = r_y;
  assign o_last   = w_row_end && (r_row == LastIdx);

endmodule

// File: rtl/grid_draw_scheduler.sv
// Walks a snapshot of the board, clearing then enabling the tile draw stage per cell.
// Define SKIP_BLANK_EN to skip CLEAR/DRAW for cells whose tile id is 0.
module grid_draw_scheduler
  import grid_draw_pkg::*;
#(
  parameter int unsigned GRID_N      = 3,
  parameter int unsigned TILE_PX     = 32,
  parameter int unsigned ORIGIN_X    = 32,
  parameter int unsigned ORIGIN_Y    = 16,
  parameter int unsigned CELL_CYCLES = DEF_CELL_CYCLES
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [GRID_N*GRID_N*TILE_ID_W-1:0] i_board_state,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [X_W-1:0]                  o_x_base,
  output logic [Y_W-1:0]                  o_y_base,
  output logic [TILE_ID_W-1:0]            o_tile_id,
  output logic                            o_draw_en,
  output logic                            o_draw_clr
);

  localparam int unsigned SNAP_W  = GRID_N * GRID_N * TILE_ID_W;
  localparam int unsigned CNT_W   = $clog2(CELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CELL_CYCLES - 1);
  localparam int unsigned MAX_X   = ORIGIN_X + (GRID_N - 1) * TILE_PX + 24;
  localparam int unsigned MAX_Y   = ORIGIN_Y + (GRID_N - 1) * TILE_PX + 24;

  if (GRID_N < 2 || GRID_N > 4 || MAX_X >= SCREEN_W || MAX_Y >= SCREEN_H)
  begin : g_bad_params
    $error("grid_draw_scheduler: grid size or cell origins fall outside the screen");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [SNAP_W-1:0]       r_snap;
  logic [SNAP_MAX_W-1:0]   w_snap_ext;
  logic [1:0]              w_row;
  logic [1:0]              w_col;
  logic [CELL_W-1:0]       w_cell;
  logic [X_W-1:0]          w_x;
  logic [Y_W-1:0]          w_y;
  logic [TILE_ID_W-1:0]    w_cur_id;
  logic                    w_last;
  logic                    w_clear;
  logic                    w_advance;
  logic                    w_skip_first;
  logic                    w_skip_next;
  logic                    w_busy;

  cell_cursor #(
    .GRID_N   (GRID_N),
    .TILE_PX  (TILE_PX),
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y)
  ) u_cursor (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_x_base  (w_x),
    .o_y_base  (w_y),
    .o_last    (w_last)
  );

  always_comb begin
    w_snap_ext             = '0;
    w_snap_ext[SNAP_W-1:0] = r_snap;
  end

  // GRID_N is a small constant, so this is just a shift/add of a 2-bit row.
  assign w_cell   = CELL_W'(32'(w_row) * GRID_N + 32'(w_col));
  assign w_cur_id = tile_at(w_snap_ext, w_cell);

`ifdef SKIP_BLANK_EN
  assign w_skip_first = (i_board_state[TILE_ID_W-1:0] == '0);
  assign w_skip_next  = (tile_at(w_snap_ext, w_cell + CELL_W'(1)) == '0);
`else
  assign w_skip_first = 1'b0;
  assign w_skip_next  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_clear     = 1'b1;
          w_state_nxt = w_skip_first ? StNext : StClear;
        end
      end
      StClear: w_state_nxt = StDraw;
      StDraw: begin
        if (r_cnt == CntLast) w_state_nxt = StNext;
      end
      StNext: begin
        if (w_last) begin
          w_state_nxt = StDone;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = w_skip_next ? StNext : StClear;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_snap  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StClear) begin
        r_cnt <= '0;
      end else if (r_state == StDraw) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_clear) r_snap <= i_board_state;
    end
  end

  assign w_busy     = (r_state != StIdle);
  assign o_busy     = w_busy;
  assign o_done     = (r_state == StDone);
  assign o_draw_en  = (r_state == StDraw);
  assign o_draw_clr = (r_state == StClear);
  assign o_x_base   = w_busy ? w_x : '0;
  assign o_y_base   = w_busy ? w_y : '0;
  assign o_tile_id  = w_busy ? w_cur_id : '0;

endmodule

// File: tb/tb_grid_draw_scheduler.sv
// Directed, table-driven bench for grid_draw_scheduler (default 3x3, 321-cycle cells).
module tb_grid_draw_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [35:0] board;
  logic        busy, done, en, clr;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [3:0]  tile;
  logic [22:0] outs;

  always #5 clk = ~clk;

  grid_draw_scheduler dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_board_state (board),
    .o_busy        (busy),
    .o_done        (done),
    .o_x_base      (x),
    .o_y_base      (y),
    .o_tile_id     (tile),
    .o_draw_en     (en),
    .o_draw_clr    (clr)
  );

  assign outs = {busy, done, en, clr, x, y, tile};

`ifdef SKIP_BLANK_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif
  localparam int DoneC = Skip ? 2586 : 2908;

  typedef struct {
    int          cyc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  int   n_err = 0;
  int   n_chk = 0;
  int   cyc, en_cnt, done_cnt, done_cyc, run, run_min, run_max;

  function automatic logic [31:0] pk(input bit b, input bit d, input bit e, input bit c,
                                     input int xx, input int yy, input int tt);
    logic [7:0] x8;
    logic [6:0] y7;
    logic [3:0] t4;
    x8 = 8'(xx);
    y7 = 7'(yy);
    t4 = 4'(tt);
    return {9'd0, b, d, e, c, x8, y7, t4};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (en) begin
      run++;
      en_cnt++;
    end else if (run > 0) begin
      if (run < run_min) run_min = run;
      if (run > run_max) run_max = run;
      run = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_stats();
    cyc = 0; en_cnt = 0; done_cnt = 0; done_cyc = -1;
    run = 0; run_min = 1000000; run_max = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    board = 36'h0_8765_4321;
    clear_stats();
    tick();
    tick();
    chk("reset_outputs", 32'(outs), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_no_start", 32'(outs), 32'd0);

    // Walk 1: stray starts at 500 and in DONE, board changed mid-walk.
    vecs[0]  = '{1,        pk(1, 0, 0, 1, 32, 16, 1)};
    vecs[1]  = '{2,        pk(1, 0, 1, 0, 32, 16, 1)};
    vecs[2]  = '{322,      pk(1, 0, 1, 0, 32, 16, 1)};
    vecs[3]  = '{323,      pk(1, 0, 0, 0, 32, 16, 1)};
    vecs[4]  = '{324,      pk(1, 0, 0, 1, 64, 16, 2)};
    vecs[5]  = '{647,      pk(1, 0, 0, 1, 96, 16, 3)};
    vecs[6]  = '{970,      pk(1, 0, 0, 1, 32, 48, 4)};
    vecs[7]  = '{1293,     pk(1, 0, 0, 1, 64, 48, 5)};
    vecs[8]  = '{1616,     pk(1, 0, 0, 1, 96, 48, 6)};
    vecs[9]  = '{1939,     pk(1, 0, 0, 1, 32, 80, 7)};
    vecs[10] = '{2262,     pk(1, 0, 0, 1, 64, 80, 8)};
    vecs[11] = '{2585,     pk(1, 0, 0, !Skip, 96, 80, 0)};
    vecs[12] = '{DoneC - 1, pk(1, 0, 0, 0, 96, 80, 0)};
    vecs[13] = '{DoneC,    pk(1, 1, 0, 0, 96, 80, 0)};
    vecs[14] = '{DoneC + 1, 32'd0};
    vecs[15] = '{DoneC + 3, 32'd0};

    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      while (cyc < vecs[i].cyc) begin
        start = (cyc == 500) || (cyc == DoneC);
        if (cyc == 1000) board = 36'hF_FFFF_FFFF;
        tick();
        start = 1'b0;
      end
      chk($sformatf("walk1_vec%0d", i), 32'(outs), vecs[i].exp);
    end
    chk("walk1_done_count", 32'(done_cnt), 32'd1);
    chk("walk1_done_cycle", 32'(done_cyc), 32'(DoneC));
    chk("walk1_en_total", 32'(en_cnt), 32'((Skip ? 8 : 9) * 321));
    chk("walk1_run_min", 32'(run_min), 32'd321);
    chk("walk1_run_max", 32'(run_max), 32'd321);

    // Reset during DRAW of cell 3, then restart.
    board = 36'h0_8765_4321;
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 1200) tick();
    chk("mid_draw_cell3", 32'(outs), pk(1, 0, 1, 0, 32, 48, 4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid_walk", 32'(outs), 32'd0);
    while (cyc < 1205) tick();
    chk("idle_after_reset", 32'(outs), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_clear", 32'(outs), pk(1, 0, 0, 1, 32, 16, 1));
    tick();
    chk("restart_draw", 32'(outs), pk(1, 0, 1, 0, 32, 16, 1));
    do_reset();

    // Start held high: back-to-back walks with a single IDLE cycle between.
    clear_stats();
    start = 1'b1;
    tick();
    while (cyc < DoneC) tick();
    chk("held_done", 32'(outs), pk(1, 1, 0, 0, 96, 80, 0));
    tick();
    chk("held_idle_gap", 32'(outs), 32'd0);
    tick();
    chk("held_new_clear", 32'(outs), pk(1, 0, 0, 1, 32, 16, 1));
    start = 1'b0;
    chk("held_done_count", 32'(done_cnt), 32'd1);
    do_reset();

    // Cell 4 carries id 0: skipped with the macro, drawn without it.
    board = 36'h9_8760_4321;
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 1292) tick();
    chk("blank_prev_next", 32'(outs), pk(1, 0, 0, 0, 32, 48, 4));
    tick();
    chk("blank_cell4", 32'(outs), pk(1, 0, 0, !Skip, 64, 48, 0));
    tick();
    chk("blank_after", 32'(outs),
        Skip ? pk(1, 0, 0, 1, 96, 48, 6) : pk(1, 0, 1, 0, 64, 48, 0));
    while (cyc < 2915) tick();
    chk("blank_done_cycle", 32'(done_cyc), Skip ? 32'd2586 : 32'd2908);
    chk("blank_en_total", 32'(en_cnt), 32'((Skip ? 8 : 9) * 321));
    chk("blank_final_idle", 32'(outs), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/grid_draw_scheduler.md
Name: grid_draw_scheduler

Overview:
- Upstream sequencer for the tile-pattern draw stage (the vertical-line "blank" pattern generator and its sibling tile drawers).
- On a start request it snapshots the board state and walks the GRID_N x GRID_N cells in row-major order.
- For each cell it presents the cell's pixel base coordinates and tile id, clears the draw stage, then holds the draw stage enabled for exactly CELL_CYCLES cycles.
- Reports busy and a one-cycle done pulse; its outputs drive the draw stage's base-coordinate, enable and reset inputs directly.

Parameters:
GRID_N, 3, cells per board side (2..4)
TILE_PX, 32, pixel pitch between cell origins
ORIGIN_X, 32, x of cell (0,0)
ORIGIN_Y, 16, y of cell (0,0)
CELL_CYCLES, 321, draw-enable cycles per cell; equals the draw stage's full pattern period (counts 0..320)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request a full board redraw; sampled only in IDLE
board_state  in  GRID_N*GRID_N*4  tile id per cell, cell k at bits [4k+3:4k], 0 = empty cell
busy  out  1  high from the CLEAR of cell 0 through DONE inclusive
done  out  1  one-cycle pulse in DONE
x_base  out  8  current cell x origin (draw-stage xIn)
y_base  out  7  current cell y origin (draw-stage yIn)
tile_id  out  4  snapshot tile id of current cell
draw_en  out  1  draw-stage enable
draw_clr  out  1  active-high clear for draw-stage counters; the top level inverts it onto the stage's resetn

Behaviour:
Reset:
- Applies on any cycle, including mid-walk.
- Next state IDLE; every output 0; cell index 0.
- Snapshot register cleared.
- draw_en drops in the same edge.

States, one transition per clock:
- IDLE: if start, capture board_state into the snapshot, cell index 0, go to CLEAR. Otherwise remain.
- CLEAR (1 cycle): draw_clr=1, draw_en=0. x_base, y_base and tile_id are valid for the current cell. Go to DRAW with draw counter 0.
- DRAW (CELL_CYCLES cycles): draw_en=1, draw_clr=0. Go to NEXT when the counter reaches CELL_CYCLES-1.
- NEXT (1 cycle): draw_en=0. If the index is the last cell (GRID_N*GRID_N-1), go to DONE. Otherwise increment the index, advance the coordinates, and go to CLEAR.
- DONE (1 cycle): done=1, busy=1. Go to IDLE.

Timing:
- Start sampled at cycle 0.
- Cell k: CLEAR at cycle 1+323k, DRAW at cycles 2+323k..322+323k, NEXT at 323+323k (default CELL_CYCLES).
- Default 3x3 board: DONE at cycle 2908, IDLE at 2909.

Coordinates:
- Computed incrementally; no multiplier.
- col+1: x_base += TILE_PX.
- Row wrap: x_base = ORIGIN_X, y_base += TILE_PX.
- Widths: x 8 bits, y 7 bits, truncating. Parameters must keep every origin plus 24 within 160x120; this is checked by an elaboration-time assertion.

Handshake and data rules:
- start is ignored while busy.
- start asserted in the DONE cycle is ignored.
- start held high in IDLE begins a new walk on the first IDLE cycle.
- board_state changes during a walk have no effect; only the snapshot is used.
- x_base, y_base and tile_id are stable from CLEAR through NEXT of each cell.

Optional Feature:
SKIP_BLANK_EN
- Defined: a cell whose snapshot tile id is 0 skips CLEAR and DRAW. The walk goes directly to that cell's NEXT state (from IDLE, or from the previous NEXT). The coordinates still advance. draw_en and draw_clr stay 0 for that cell. The skipped cell costs 1 cycle.
- Undefined: every cell is drawn, including id 0.

Decomposition:
- Package grid_draw_pkg holds:
  - state enum (IDLE, CLEAR, DRAW, NEXT, DONE)
  - TILE_ID_W=4, X_W=8, Y_W=7
  - default CELL_CYCLES=321 and screen limits 160/120
- Sub-module cell_cursor owns the row/col counters and incremental x_base/y_base. Its inputs are clear and advance; its outputs are row, col, x_base, y_base and last.

Test Plan:
1. Reset, then start pulse with board_state = ids 1..8 and 0 at cell 8 -> CLEAR at cycle 1 with x/y=32/16, tile_id=1. draw_en high for exactly 321 cycles (2..322).
2. Same run -> base coordinates per cell: (32,16), (64,16), (96,16), (32,48) … (96,80). done pulses only at cycle 2908. busy falls at cycle 2909.
3. start re-pulsed at cycles 500 and 2908, and board_state changed at cycle 1000 -> no restart. Cells 3..8 still carry the snapshot ids.
4. reset asserted at cycle 1200, during DRAW of cell 3 -> next cycle IDLE with all outputs 0. A new start at cycle 1205 restarts at cell 0, x/y=32/16.
5. SKIP_BLANK_EN defined, cell 4 id 0 -> cell 4 gets no draw_clr or draw_en. Cell 5 CLEAR at cycle 1+323*4+1=1294. done at cycle 2586.
6. start held high continuously -> back-to-back walks. A new CLEAR occurs at cycle 2910 (one IDLE cycle after DONE).
